// File: rtl/pcie_dllp_tx_gen.sv
// -----------------------------------------------------------------------------
// pcie_dllp_tx_gen
//
// Builds 6-byte PCIe DLLPs (Ack, Nak, InitFC1, InitFC2, UpdateFC) and presents
// them to the downstream TX mux through a single valid/ready output register.
//
// Pending Ack/Nak requests and per-channel UpdateFC requests are tracked
// internally. One DLLP is selected per free output slot with fixed priority
// Nak > Ack > FC. FC DLLPs rotate over the channels round-robin. The CRC16 is
// computed combinationally on the selected DLLP before it is loaded.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ack_req_i         request an Ack carrying acknak_seq_i
//   nak_req_i         request a Nak carrying acknak_seq_i (wins over Ack)
//   acknak_seq_i      sequence number for Ack/Nak
//   fc_phase_i        0 inactive, 1 InitFC1, 2 InitFC2, 3 FC active
//   hdr_credit_i      header credits, channel k at [k*HDR_FC_BITS +: HDR_FC_BITS]
//   data_credit_i     data credits, channel k at [k*DATA_FC_BITS +: DATA_FC_BITS]
//   credit_upd_i      per-channel pulse requesting an UpdateFC
//   dllp_valid_o      output register holds a DLLP
//   dllp_data_o       [7:0] byte0 (type) .. [31:24] byte3,
//                     [39:32] byte4 and [47:40] byte5 (the CRC16 bytes)
//   dllp_ready_i      downstream accepts when valid & ready
//   acknak_sent_o     high in the accept cycle of an Ack or Nak
// -----------------------------------------------------------------------------
module pcie_dllp_tx_gen #(
  parameter int unsigned SEQ_BITS     = 12,
  parameter int unsigned FC_CH        = 3,
  parameter int unsigned HDR_FC_BITS  = 8,
  parameter int unsigned DATA_FC_BITS = 12,
  parameter logic [1:0]  HDR_SCALE    = 2'b00,
  parameter logic [1:0]  DATA_SCALE   = 2'b00,
  parameter logic [2:0]  VC_ID        = 3'd0,
  parameter int unsigned UPDFC_TIMER  = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ack_req_i,
  input  logic                           nak_req_i,
  input  logic [SEQ_BITS-1:0]            acknak_seq_i,
  input  logic [1:0]                     fc_phase_i,
  input  logic [FC_CH*HDR_FC_BITS-1:0]   hdr_credit_i,
  input  logic [FC_CH*DATA_FC_BITS-1:0]  data_credit_i,
  input  logic [FC_CH-1:0]               credit_upd_i,
  output logic                           dllp_valid_o,
  output logic [47:0]                    dllp_data_o,
  input  logic                           dllp_ready_i,
  output logic                           acknak_sent_o
);

  localparam int TMR_W = (UPDFC_TIMER > 1) ? $clog2(UPDFC_TIMER) : 1;
  localparam int RR_W  = (FC_CH > 1) ? $clog2(FC_CH) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPDFC_TIMER - 1);

  typedef enum logic [1:0] {
    PH_INACTIVE = 2'd0,
    PH_INIT1    = 2'd1,
    PH_INIT2    = 2'd2,
    PH_ACTIVE   = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_ACK,
    K_NAK,
    K_INITFC1,
    K_INITFC2,
    K_UPDFC
  } dllp_kind_e;

  // ---------------------------------------------------------------------------
  // CRC16 over bytes 0..3: poly 0x100B, seed 0xFFFF, byte0 bit0 shifted first.
  // The remainder is complemented and bit-reversed within each byte:
  // byte4[7:0] = ~crc[8..15], byte5[7:0] = ~crc[0..7]. Returns {byte5, byte4}.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] dllp_crc16(input logic [31:0] dw);
    logic [15:0] lfsr;
    logic [15:0] res;
    logic        fb;
    lfsr = 16'hFFFF;
    res  = '0;
    for (int i = 0; i < 32; i++) begin
      fb   = dw[i] ^ lfsr[15];
      lfsr = {lfsr[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    for (int b = 0; b < 8; b++) begin
      res[b]     = ~lfsr[15-b];
      res[8 + b] = ~lfsr[7-b];
    end
    return res;
  endfunction

  // State
  logic                 r_valid;
  logic [47:0]          r_data;
  logic                 r_is_acknak;
  logic                 r_ack_pend;
  logic [SEQ_BITS-1:0]  r_ack_seq;
  logic                 r_nak_pend;
  logic [SEQ_BITS-1:0]  r_nak_seq;
  logic [FC_CH-1:0]     r_upd_pend;
  logic [TMR_W-1:0]     r_timer;
  logic [RR_W-1:0]      r_rr;      // next channel to consider for FC DLLPs

  // Combinational
  phase_e               w_phase;
  logic                 w_ack_new;
  logic                 w_nak_eff;
  logic                 w_ack_eff;
  logic [SEQ_BITS-1:0]  w_nak_seq;
  logic [SEQ_BITS-1:0]  w_ack_seq;
  logic                 w_upd_found;
  logic [RR_W-1:0]      w_upd_ch;
  dllp_kind_e           w_kind;
  logic [RR_W-1:0]      w_ch;
  logic                 w_load;
  logic                 w_expire;
  logic [FC_CH-1:0]     w_upd_clr;
  logic [7:0]           w_hdr8;
  logic [11:0]          w_data12;
  logic [11:0]          w_seq12;
  logic [7:0]           w_byte0;
  logic [7:0]           w_byte1;
  logic [7:0]           w_byte2;
  logic [7:0]           w_byte3;
  logic [31:0]          w_dw;
  logic [15:0]          w_crc;

  assign w_phase = phase_e'(fc_phase_i);

  // A request seen this cycle competes immediately, so a request at cycle N
  // with a free output register is visible at N+1. Nak and Ack in the same
  // cycle keep only the Nak.
  assign w_ack_new = ack_req_i & ~nak_req_i;
  assign w_nak_eff = r_nak_pend | nak_req_i;
  assign w_ack_eff = r_ack_pend | w_ack_new;
  assign w_nak_seq = nak_req_i ? acknak_seq_i : r_nak_seq;
  assign w_ack_seq = w_ack_new ? acknak_seq_i : r_ack_seq;

  assign w_expire = (w_phase == PH_ACTIVE) && (r_timer == TMR_LAST);

  // Round-robin search of pending UpdateFC channels, starting at r_rr.
  always_comb begin : upd_search
    int idx;
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_upd_found = 1'b0;
    w_upd_ch    = '0;
    idx         = 0;
    for (int i = 0; i < int'(FC_CH); i++) begin
      idx = int'(r_rr) + i;
      if (idx >= int'(FC_CH)) idx = idx - int'(FC_CH);
      if (!w_upd_found && r_upd_pend[idx]) begin
        w_upd_found = 1'b1;
        w_upd_ch    = RR_W'(idx);
      end
    end
  end

  // Arbitration: Nak > Ack > FC. Nothing new is issued in the inactive phase.
  always_comb begin
    w_kind = K_NONE;
    w_ch   = r_rr;
    if (w_phase != PH_INACTIVE) begin
      if (w_nak_eff) begin
        w_kind = K_NAK;
      end else if (w_ack_eff) begin
        w_kind = K_ACK;
      end else if (w_phase == PH_INIT1) begin
        w_kind = K_INITFC1;
      end else if (w_phase == PH_INIT2) begin
        w_kind = K_INITFC2;
      end else if (w_upd_found) begin
        w_kind = K_UPDFC;
        w_ch   = w_upd_ch;
      end
    end
  end

  assign w_load = (!r_valid || dllp_ready_i) && (w_kind != K_NONE);

  always_comb begin
    w_upd_clr = '0;
    if (w_load && (w_kind == K_UPDFC)) w_upd_clr[w_ch] = 1'b1;
  end

  // Credits of the selected channel, zero-extended to the DLLP field widths.
  always_comb begin
    w_hdr8   = '0;
    w_data12 = '0;
    for (int k = 0; k < int'(FC_CH); k++) begin
      if (int'(w_ch) == k) begin
        w_hdr8   = 8'(hdr_credit_i[k*HDR_FC_BITS +: HDR_FC_BITS]);
        w_data12 = 12'(data_credit_i[k*DATA_FC_BITS +: DATA_FC_BITS]);
      end
    end
  end

  // DLLP body assembly.
  always_comb begin
    w_seq12 = (w_kind == K_NAK) ? 12'(w_nak_seq) : 12'(w_ack_seq);
    w_byte0 = 8'h00;
    w_byte1 = {HDR_SCALE, w_hdr8[7:2]};
    w_byte2 = {w_hdr8[1:0], DATA_SCALE, w_data12[11:8]};
    w_byte3 = w_data12[7:0];
    case (w_kind)
      K_ACK, K_NAK: begin
        w_byte0 = (w_kind == K_NAK) ? 8'h10 : 8'h00;
        w_byte1 = 8'h00;
        w_byte2 = {4'b0000, w_seq12[11:8]};
        w_byte3 = w_seq12[7:0];
      end
      K_INITFC1: w_byte0 = {2'b01, 2'(w_ch), 1'b0, VC_ID};
      K_INITFC2: w_byte0 = {2'b11, 2'(w_ch), 1'b0, VC_ID};
      K_UPDFC:   w_byte0 = {2'b10, 2'(w_ch), 1'b0, VC_ID};
      default:   w_byte0 = 8'h00;
    endcase
    w_dw  = {w_byte3, w_byte2, w_byte1, w_byte0};
    w_crc = dllp_crc16(w_dw);
  end

  // Pending request tracking, UpdateFC timer and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here is a handful of control flops, so every one is reset.
    if (!rst_n) begin
      r_ack_pend <= 1'b0;
      r_ack_seq  <= '0;
      r_nak_pend <= 1'b0;
      r_nak_seq  <= '0;
      r_upd_pend <= '0;
      r_timer    <= '0;
      r_rr       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (nak_req_i) r_nak_seq <= acknak_seq_i;
      if (w_ack_new) r_ack_seq <= acknak_seq_i;

      if (w_phase == PH_INACTIVE) begin
        r_ack_pend <= 1'b0;
        r_nak_pend <= 1'b0;
        r_upd_pend <= '0;
      end else begin
        r_nak_pend <= w_nak_eff & ~(w_load && (w_kind == K_NAK));
        // A loaded Nak supersedes an older pending Ack.
        r_ack_pend <= (w_ack_new | (r_ack_pend & ~(w_load && (w_kind == K_NAK))))
                      & ~(w_load && (w_kind == K_ACK));
        // Set wins over the clear of a channel loaded in the same cycle.
        r_upd_pend <= (r_upd_pend & ~w_upd_clr) | credit_upd_i
                      | (w_expire ? {FC_CH{1'b1}} : {FC_CH{1'b0}});
      end

      if (w_phase != PH_ACTIVE || w_expire) r_timer <= '0;
      else                                  r_timer <= r_timer + 1'b1;

      if (w_load && (w_kind == K_INITFC1 || w_kind == K_INITFC2 || w_kind == K_UPDFC)) begin
        if (int'(w_ch) == int'(FC_CH) - 1) r_rr <= '0;
        else                               r_rr <= RR_W'(int'(w_ch) + 1);
      end
    end
  end

  // Output register: loads when empty or drained this cycle, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_is_acknak <= 1'b0;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_data      <= {w_crc, w_dw};
      r_is_acknak <= (w_kind == K_ACK) || (w_kind == K_NAK);
    end else if (dllp_ready_i) begin
      r_valid     <= 1'b0;
    end
  end

  assign dllp_valid_o  = r_valid;
  assign dllp_data_o   = r_data;
  assign acknak_sent_o = r_valid & dllp_ready_i & r_is_acknak;

endmodule

// File: tb/tb_pcie_dllp_tx_gen.sv
// -----------------------------------------------------------------------------
// tb_pcie_dllp_tx_gen
//
// Directed bench for pcie_dllp_tx_gen. Ack/Nak handshakes are applied from a
// table of per-cycle {inputs, expected outputs}; FC rotation, backpressure,
// UpdateFC timing, phase-0 flush and mid-packet reset use short hand-written
// sequences. CRC bytes come from a polynomial long-division model.
// -----------------------------------------------------------------------------
module tb_pcie_dllp_tx_gen;

  localparam int unsigned TMR = 16;

  logic        clk;
  logic        rst_n;
  logic        ack_req;
  logic        nak_req;
  logic [11:0] acknak_seq;
  logic [1:0]  fc_phase;
  logic [23:0] hdr_credit;
  logic [35:0] data_credit;
  logic [2:0]  credit_upd;
  logic        dllp_valid;
  logic [47:0] dllp_data;
  logic        dllp_ready;
  logic        acknak_sent;

  int n_cmp  = 0;
  int n_fail = 0;

  pcie_dllp_tx_gen #(
    .SEQ_BITS    (12),
    .FC_CH       (3),
    .HDR_FC_BITS (8),
    .DATA_FC_BITS(12),
    .HDR_SCALE   (2'b00),
    .DATA_SCALE  (2'b00),
    .VC_ID       (3'd0),
    .UPDFC_TIMER (TMR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ack_req_i    (ack_req),
    .nak_req_i    (nak_req),
    .acknak_seq_i (acknak_seq),
    .fc_phase_i   (fc_phase),
    .hdr_credit_i (hdr_credit),
    .data_credit_i(data_credit),
    .credit_upd_i (credit_upd),
    .dllp_valid_o (dllp_valid),
    .dllp_data_o  (dllp_data),
    .dllp_ready_i (dllp_ready),
    .acknak_sent_o(acknak_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ack;
    logic        nak;
    logic [11:0] seq;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_dw;
    logic        exp_sent;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Message bits in transmit order (byte0 bit0 first) form a polynomial with
  // the first bit at x^47; the seed is folded in by inverting the first 16 bits.
  function automatic logic [15:0] golden_crc(input logic [31:0] dw);
    logic [47:0] v;
    logic [15:0] rem;
    logic [15:0] res;
    v = '0;
    for (int i = 0; i < 32; i++) v[47-i] = dw[i];
    v[47:32] = ~v[47:32];
    for (int i = 47; i >= 16; i--)
      if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h1100B;
    rem = v[15:0];
    res = '0;
    for (int b = 0; b < 8; b++) begin
      res[b]     = ~rem[15-b];
      res[8 + b] = ~rem[7-b];
    end
    return res;
  endfunction

  function automatic logic [47:0] exp48(input logic [31:0] dw);
    return {golden_crc(dw), dw};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ack_req    = 1'b0;
    nak_req    = 1'b0;
    acknak_seq = '0;
    fc_phase   = 2'd0;
    credit_upd = '0;
    dllp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [47:0] held;
  logic [31:0] exp_fc[3];

  initial begin
    hdr_credit  = {8'h03, 8'hFF, 8'h20};
    data_credit = {12'h123, 12'hFFF, 12'h080};
    exp_fc[0]   = 32'h8000_0840;
    exp_fc[1]   = 32'hFFCF_3F50;
    exp_fc[2]   = 32'h23C1_0060;

    // ---- Reset state ----
    do_reset();
    check("reset valid", dllp_valid, 1'b0);
    check("reset data", dllp_data, 48'h0);
    check("reset sent", acknak_sent, 1'b0);

    // ---- T1/T2 and a Nak under backpressure, table driven (phase 3) ----
    //           ack  nak  seq      rdy  e_val e_dw          e_sent
    vecs[0]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 12'h123, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 32'h2301_0000, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 1'b1, 12'h7FF, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 32'hFF07_0010, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b1, 12'h005, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 32'h0500_0010, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 32'h0500_0010, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 32'h0,         1'b0};

    fc_phase = 2'd3;
    for (int i = 0; i < 12; i++) begin
      ack_req    = vecs[i].ack;
      nak_req    = vecs[i].nak;
      acknak_seq = vecs[i].seq;
      dllp_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d valid", i), dllp_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d data", i), dllp_data, exp48(vecs[i].exp_dw));
      check($sformatf("vec%0d sent", i), acknak_sent, vecs[i].exp_sent);
      tick();
    end
    ack_req = 1'b0;
    nak_req = 1'b0;

    // ---- T3: InitFC1 rotation, then InitFC2 ----
    do_reset();
    dllp_ready = 1'b1;
    fc_phase   = 2'd1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3 valid %0d", i), dllp_valid, 1'b1);
      check($sformatf("t3 data %0d", i), dllp_data, exp48(exp_fc[i % 3]));
      check($sformatf("t3 sent %0d", i), acknak_sent, 1'b0);
      tick();
    end
    fc_phase = 2'd2;
    check("t3 initfc1 ch0 again", dllp_data, exp48(exp_fc[0]));
    tick();
    check("t3 initfc2 ch1", dllp_data, exp48(32'hFFCF_3FD0));

    // ---- T4: backpressure on UpdateFC, Ack seq overwritten while blocked ----
    do_reset();
    fc_phase   = 2'd3;
    credit_upd = 3'b001;
    tick();
    credit_upd = 3'b000;
    check("t4 not yet valid", dllp_valid, 1'b0);
    tick();
    check("t4 updfc valid", dllp_valid, 1'b1);
    check("t4 updfc data", dllp_data, exp48(32'h8000_0880));
    held       = dllp_data;
    ack_req    = 1'b1;
    acknak_seq = 12'h010;
    tick();
    acknak_seq = 12'h011;
    check("t4 hold c3", dllp_data, held);
    tick();
    ack_req = 1'b0;
    check("t4 hold c4", dllp_data, held);
    tick();
    check("t4 hold c5", dllp_data, held);
    tick();
    check("t4 hold c6", {dllp_valid, dllp_data}, {1'b1, held});
    tick();
    dllp_ready = 1'b1;
    #1;
    check("t4 hold at accept", {dllp_valid, dllp_data}, {1'b1, held});
    check("t4 updfc not acknak", acknak_sent, 1'b0);
    tick();
    check("t4 ack valid", dllp_valid, 1'b1);
    check("t4 ack 0x011", dllp_data, exp48(32'h1100_0000));
    check("t4 ack sent", acknak_sent, 1'b1);
    tick();
    check("t4 no second ack", dllp_valid, 1'b0);
    tick();
    check("t4 idle", dllp_valid, 1'b0);

    // ---- T5: UpdateFC timer rounds and a credit pulse ----
    do_reset();
    dllp_ready = 1'b1;
    fc_phase   = 2'd3;
    for (int c = 0; c < 37; c++) begin
      if (c >= 17 && ((c - 17) % 16) < 3) begin
        check($sformatf("t5 c%0d valid", c), dllp_valid, 1'b1);
        check($sformatf("t5 c%0d type", c), dllp_data[7:0], 8'h80 + 8'(16 * ((c - 17) % 16)));
      end else begin
        check($sformatf("t5 c%0d idle", c), dllp_valid, 1'b0);
      end
      tick();
    end
    credit_upd = 3'b010;
    tick();
    credit_upd = 3'b000;
    check("t5 pulse +1 idle", dllp_valid, 1'b0);
    tick();
    check("t5 pulse +2 valid", dllp_valid, 1'b1);
    check("t5 pulse +2 ch1", dllp_data, exp48(32'hFFCF_3F90));
    tick();
    check("t5 after ch1 idle", dllp_valid, 1'b0);

    // ---- T6: asynchronous reset while valid & !ready ----
    do_reset();
    fc_phase   = 2'd3;
    ack_req    = 1'b1;
    acknak_seq = 12'h042;
    tick();
    ack_req = 1'b0;
    check("t6 valid before reset", dllp_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6 valid drops", dllp_valid, 1'b0);
    check("t6 data cleared", dllp_data, 48'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    dllp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t6 no replay %0d", c), dllp_valid, 1'b0);
      tick();
    end
    ack_req    = 1'b1;
    acknak_seq = 12'h001;
    tick();
    ack_req = 1'b0;
    check("t6 new ack", {dllp_valid, dllp_data}, {1'b1, exp48(32'h0100_0000)});

    // ---- T7: phase 0 drops pending work, in-flight DLLP still completes ----
    do_reset();
    fc_phase   = 2'd3;
    ack_req    = 1'b1;
    acknak_seq = 12'h0AA;
    tick();
    acknak_seq = 12'h0BB;
    check("t7 ack AA", dllp_data, exp48(32'hAA00_0000));
    tick();
    ack_req  = 1'b0;
    fc_phase = 2'd0;
    check("t7 ack AA held", {dllp_valid, dllp_data}, {1'b1, exp48(32'hAA00_0000)});
    tick();
    dllp_ready = 1'b1;
    #1;
    check("t7 in-flight sent", acknak_sent, 1'b1);
    tick();
    check("t7 pending dropped", dllp_valid, 1'b0);
    tick();
    check("t7 still idle", dllp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
